// File: rtl/hc595_serial_rx.sv
// hc595_serial_rx: oversampled 74HC595 three-wire receiver rebuilding the storage register with frame checks
module hc595_serial_rx #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 12000,
  localparam int CW = $clog2(2*WIDTH)+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_data,
  input  logic             i_data_clk,
  input  logic             i_refresh_clk,
  output logic [WIDTH-1:0] o_buf,
  output logic             o_valid,
  output logic             o_frame_err,
  output logic             o_timeout,
  output logic [CW-1:0]    o_bit_cnt
);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam int MW = $clog2(SYNC_STAGES+2);
  typedef enum logic {IDLE, SHIFTING} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync_data, sync_dclk, sync_rclk;
  logic hist_dclk, hist_rclk, armed, d_rise, r_rise, expire;
  logic [MW-1:0] mask;
  logic [TW-1:0] tcnt;
  logic [WIDTH-1:0] sr, shifted;
  logic [CW-1:0] cnt_inc;
  always_comb begin
    state = (o_bit_cnt != '0) ? SHIFTING : IDLE;
    armed = mask == MW'(SYNC_STAGES+1);
    d_rise = armed & sync_dclk[SYNC_STAGES-1] & ~hist_dclk;
    r_rise = armed & sync_rclk[SYNC_STAGES-1] & ~hist_rclk;
    shifted = MSB_FIRST ? {sr[WIDTH-2:0], sync_data[SYNC_STAGES-1]} : {sync_data[SYNC_STAGES-1], sr[WIDTH-1:1]};
    cnt_inc = (o_bit_cnt == CW'(2*WIDTH)) ? o_bit_cnt : o_bit_cnt + CW'(1);
    expire = (state == SHIFTING) & (tcnt == TW'(TIMEOUT-1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_data <= '0;
      sync_dclk <= '0;
      sync_rclk <= '0;
      hist_dclk <= 1'b0;
      hist_rclk <= 1'b0;
      mask <= '0;
      sr <= '0;
      tcnt <= '0;
      o_buf <= '0;
      o_valid <= 1'b0;
      o_frame_err <= 1'b0;
      o_timeout <= 1'b0;
      o_bit_cnt <= '0;
    end else begin
      sync_data <= {sync_data[SYNC_STAGES-2:0], i_data};
      sync_dclk <= {sync_dclk[SYNC_STAGES-2:0], i_data_clk};
      sync_rclk <= {sync_rclk[SYNC_STAGES-2:0], i_refresh_clk};
      hist_dclk <= sync_dclk[SYNC_STAGES-1];
      hist_rclk <= sync_rclk[SYNC_STAGES-1];
      mask <= armed ? mask : mask + MW'(1);
      o_valid <= r_rise;
      o_timeout <= ~r_rise & ~d_rise & expire;
      if (d_rise) sr <= shifted;
      if (r_rise) begin
        o_buf <= sr;
        o_frame_err <= o_bit_cnt != CW'(WIDTH);
      end
      o_bit_cnt <= r_rise ? (d_rise ? CW'(1) : '0) : d_rise ? cnt_inc : expire ? '0 : o_bit_cnt;
      tcnt <= (r_rise | d_rise) ? '0 : expire ? TW'(TIMEOUT) : (state == SHIFTING) ? tcnt + TW'(1) : tcnt;
    end
  end
endmodule

// File: tb/tb_hc595_serial_rx.sv
// tb_hc595_serial_rx: scoreboard bench for the 74HC595 receiver
module tb_hc595_serial_rx;
  logic clk = 1'b0;
  logic rst, i_data, i_data_clk, i_refresh_clk;
  logic [7:0] o_buf;
  logic o_valid, o_frame_err, o_timeout;
  logic [4:0] o_bit_cnt;
  typedef struct {logic [7:0] b; logic e; logic [4:0] c;} exp_t;
  exp_t q[$];
  int checks = 0, fails = 0, nvalid = 0, nto = 0, to0;
  hc595_serial_rx #(.WIDTH(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_data_clk(i_data_clk),
    .i_refresh_clk(i_refresh_clk), .o_buf(o_buf), .o_valid(o_valid),
    .o_frame_err(o_frame_err), .o_timeout(o_timeout), .o_bit_cnt(o_bit_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic shift_bit(input logic b);
    i_data = b;
    step(2);
    i_data_clk = 1'b1;
    step(2);
    i_data_clk = 1'b0;
    step(2);
  endtask
  task automatic send(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) shift_bit(v[i]);
  endtask
  task automatic refresh(input logic [7:0] b, input logic e);
    q.push_back('{b: b, e: e, c: 5'd0});
    i_refresh_clk = 1'b1;
    step(2);
    i_refresh_clk = 1'b0;
    step(2);
  endtask
  task automatic tied(input logic [7:0] b);
    q.push_back('{b: b, e: 1'b1, c: 5'd1});
    i_data_clk = 1'b1;
    i_refresh_clk = 1'b1;
    step(2);
    i_data_clk = 1'b0;
    i_refresh_clk = 1'b0;
    step(2);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (o_timeout) nto++;
      if (o_valid) begin
        nvalid++;
        if (q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          exp_t x;
          x = q.pop_front();
          chk("sb_buf", o_buf, x.b);
          chk("sb_frame_err", o_frame_err, x.e);
          chk("sb_bit_cnt", o_bit_cnt, x.c);
          chk("sb_no_timeout", o_timeout, 0);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    i_data = 1'b1;
    i_data_clk = 1'b1;
    i_refresh_clk = 1'b1;
    step(3);
    rst = 1'b0;
    step(10);
    chk("reset_no_valid", nvalid, 0);
    chk("reset_bit_cnt", o_bit_cnt, 0);
    chk("reset_buf", o_buf, 8'h00);
    chk("reset_frame_err", o_frame_err, 0);
    i_data = 1'b0;
    i_data_clk = 1'b0;
    i_refresh_clk = 1'b0;
    step(4);
    chk("lines_low_bit_cnt", o_bit_cnt, 0);
    send(8'hA5, 8);
    chk("a5_bit_cnt_pre", o_bit_cnt, 8);
    q.push_back('{b: 8'hA5, e: 1'b0, c: 5'd0});
    i_refresh_clk = 1'b1;
    step(2);
    chk("latency_not_yet", o_valid, 0);
    step(1);
    chk("latency_valid", o_valid, 1);
    i_refresh_clk = 1'b0;
    step(3);
    chk("a5_bit_cnt_post", o_bit_cnt, 0);
    send(8'hF8, 5);
    refresh(8'hBF, 1'b1);
    chk("short_frame_err", o_frame_err, 1);
    send(8'h3C, 8);
    refresh(8'h3C, 1'b0);
    chk("recover_frame_err", o_frame_err, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    i_data = 1'b1;
    step(5);
    for (int k = 1; k <= 8; k++) tied(8'((1 << (k - 1)) - 1));
    step(2);
    chk("tied_buf", o_buf, 8'h7F);
    chk("tied_sr", dut.sr, 8'hFF);
    chk("tied_bit_cnt", o_bit_cnt, 1);
    to0 = nto;
    step(60);
    chk("tied_tail_timeout", nto - to0, 1);
    send(8'hA0, 3);
    to0 = nto;
    step(60);
    chk("timeout_once", nto - to0, 1);
    chk("timeout_bit_cnt", o_bit_cnt, 0);
    chk("timeout_buf_kept", o_buf, 8'h7F);
    send(8'h81, 8);
    refresh(8'h81, 1'b0);
    chk("post_timeout_err", o_frame_err, 0);
    send(8'h5A, 4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(5);
    chk("midrst_bit_cnt", o_bit_cnt, 0);
    chk("midrst_buf", o_buf, 8'h00);
    send(8'h5A, 8);
    refresh(8'h5A, 1'b0);
    step(10);
    chk("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
